// File: rtl/add_pipe_stage.sv
// rtl/add_pipe_stage.sv - two-stage valid/ready pipeline around a carry-lookahead adder
// Optional saturation on signed overflow is enabled by defining ADD_PIPE_SAT_EN.

module add_pipe_cla #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       grp_g;
    logic       grp_p;
    logic       carry;

    // Each 4-bit group resolves its internal carries in parallel; groups chain on group G/P.
    always_comb begin
        g     = '0;
        p     = '0;
        c     = '0;
        grp_g = 1'b0;
        grp_p = 1'b0;
        carry = cin;
        sum   = '0;
        for (int k = 0; k < WIDTH / 4; k++) begin
            g     = a[4*k +: 4] & b[4*k +: 4];
            p     = a[4*k +: 4] ^ b[4*k +: 4];
            c[0]  = carry;
            c[1]  = g[0] | (p[0] & carry);
            c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
            c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
            grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
            grp_p = &p;
            sum[4*k +: 4] = p ^ c;
            carry = grp_g | (grp_p & carry);
        end
        cout = carry;
    end
endmodule

module add_pipe_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             sticky_ovf,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] result_cnt
);
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] raw_sum;
    logic             raw_cout;
    logic             raw_ovf;
    logic             s2_free;
    logic             s1_adv;
    logic             accept;
    logic             deliver;

    add_pipe_cla #(.WIDTH(WIDTH)) u_cla (
        .a    (a_q),
        .b    (b_q),
        .cin  (cin_q),
        .sum  (raw_sum),
        .cout (raw_cout)
    );

    assign raw_ovf = ~(a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ raw_sum[WIDTH-1]);
    assign s2_free = !out_valid_q | out_ready;
    assign s1_adv  = s1_valid_q & s2_free;
    assign accept  = in_valid & in_ready;
    assign deliver = out_valid_q & out_ready;

    always_comb begin
        s1_valid_d  = accept | (s1_valid_q & !s2_free);
        a_d         = accept ? in_a   : a_q;
        b_d         = accept ? in_b   : b_q;
        cin_d       = accept ? in_cin : cin_q;
        out_valid_d = s1_adv | (out_valid_q & !out_ready);
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        if (s1_adv) begin
            sum_d  = raw_sum;
            cout_d = raw_cout;
            ovf_d  = raw_ovf;
`ifdef ADD_PIPE_SAT_EN
            if (raw_ovf) begin
                sum_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end
`endif
        end
        // A same-cycle overflowing delivery outranks the clear.
        sticky_d = (deliver & ovf_q) | (sticky_q & !sticky_clr);
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, deliver};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready   = !s1_valid_q | s2_free;
    assign out_valid  = out_valid_q;
    assign out_sum    = sum_q;
    assign out_cout   = cout_q;
    assign out_ovf    = ovf_q;
    assign sticky_ovf = sticky_q;
    assign result_cnt = cnt_q;
endmodule

// File: tb/tb_add_pipe_stage.sv
// tb/tb_add_pipe_stage.sv - scoreboard bench for add_pipe_stage (WIDTH=32, CNT_W=2)

module tb_add_pipe_stage;
    localparam int W = 32;
    localparam int CW = 2;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_cin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;
    logic          sticky_ovf;
    logic          sticky_clr = 1'b0;
    logic [CW-1:0] result_cnt;

    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    int   deliv_cyc[$];
    int   cyc = 0;
    int   model_cnt = 0;
    bit   model_sticky = 0;
    bit   rand_ready = 0;
    bit   forced_ready = 0;
    bit   forced_clr = 0;

    add_pipe_stage #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .out_ovf    (out_ovf),
        .sticky_ovf (sticky_ovf),
        .sticky_clr (sticky_clr),
        .result_cnt (result_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t        e;
        logic [W:0]  full;
        longint      s;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        s      = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`ifdef ADD_PIPE_SAT_EN
        if (s > 64'sd2147483647) e.sum = 32'h7FFF_FFFF;
        else if (s < -64'sd2147483648) e.sum = 32'h8000_0000;
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        out_ready  = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
        sticky_clr = rand_ready ? ($urandom_range(0, 7) == 0) : forced_clr;
    end

    // Monitor: samples settled outputs mid-cycle; the delivery happens at the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (rst) begin
                exp_q.delete();
                model_cnt    = 0;
                model_sticky = 0;
            end else begin
                chk("result_cnt", 64'(result_cnt), 64'(model_cnt));
                chk("sticky_ovf", 64'(sticky_ovf), 64'(model_sticky));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_sum", 64'(out_sum), 64'(e.sum));
                        chk("out_cout", 64'(out_cout), 64'(e.cout));
                        chk("out_ovf", 64'(out_ovf), 64'(e.ovf));
                        model_sticky = e.ovf || (model_sticky && !sticky_clr);
                        deliv_cyc.push_back(cyc);
                    end
                    model_cnt = (model_cnt + 1) % (1 << CW);
                end else if (sticky_clr) begin
                    model_sticky = 0;
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int waited;
        bit done;
        @(negedge clk);
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        done = 0; waited = 0;
        while (!done) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                exp_q.push_back(model(a, b, c));
                done = 1;
            end else begin
                waited++;
                if (waited > 200) begin
                    chk("send_timeout", 64'(1), 64'(0));
                    done = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        #1 in_valid = 1'b0;
    endtask

    // Issue into an empty pipe with out_ready=1 and check the result one edge after acceptance.
    task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic [W-1:0] s, input logic co, input logic ov);
        send(a, b, c);
        @(posedge clk);
        #1;
        chk({name, "_valid"}, 64'(out_valid), 64'(1));
        chk({name, "_sum"}, 64'(out_sum), 64'(s));
        chk({name, "_cout"}, 64'(out_cout), 64'(co));
        chk({name, "_ovf"}, 64'(out_ovf), 64'(ov));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int nd;
        logic [W-1:0] a, b;
        logic [W-1:0] sat_pos, sat_neg;
`ifdef ADD_PIPE_SAT_EN
        sat_pos = 32'h7FFF_FFFF;
        sat_neg = 32'h8000_0000;
`else
        sat_pos = 32'h8000_0000;
        sat_neg = 32'h7FFF_FFFF;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_sum", 64'(out_sum), 64'(0));
        chk("rst_out_ovf", 64'(out_ovf), 64'(0));
        chk("rst_sticky", 64'(sticky_ovf), 64'(0));
        chk("rst_cnt", 64'(result_cnt), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        forced_ready = 1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);

        directed("single", 32'h5, 32'h3, 1'b1, 32'h9, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("cnt_after_first", 64'(result_cnt), 64'(1));
        directed("carry", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);
        directed("pos_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, sat_pos, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("sticky_after_ovf", 64'(sticky_ovf), 64'(1));
        directed("neg_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, sat_neg, 1'b1, 1'b1);
        directed("fifth", 32'h10, 32'h20, 1'b0, 32'h30, 1'b0, 1'b0);
        drain();
        chk("cnt_wrap", 64'(result_cnt), 64'(1));

        // Back-pressure: two accepts fill both stages, then in_ready drops.
        forced_ready = 0;
        @(posedge clk);
        send(32'h1, 32'h2, 1'b0);
        send(32'h3, 32'h4, 1'b1);
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        nd = deliv_cyc.size();
        fork
            begin
                send(32'h5, 32'h6, 1'b0);
                send(32'h7, 32'h8, 1'b1);
            end
            begin
                repeat (3) @(posedge clk);
                forced_ready = 1;
            end
        join
        drain();
        chk("bp_count", 64'(deliv_cyc.size() - nd), 64'(4));
        if (deliv_cyc.size() - nd == 4)
            chk("bp_rate", 64'(deliv_cyc[nd+3] - deliv_cyc[nd]), 64'(3));

        // Sticky: set wins over a same-cycle clear, clear alone then resets it.
        send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        forced_clr = 1;
        @(posedge clk);
        @(posedge clk); #1;
        chk("sticky_set_wins", 64'(sticky_ovf), 64'(1));
        @(posedge clk); #1;
        chk("sticky_clr_alone", 64'(sticky_ovf), 64'(0));
        forced_clr = 0;

        // Reset with both stages full.
        forced_ready = 0;
        @(posedge clk);
        send(32'hA, 32'hB, 1'b0);
        send(32'hC, 32'hD, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        chk("midrst_cnt", 64'(result_cnt), 64'(0));
        forced_ready = 1;
        repeat (10) @(posedge clk);
        directed("post_rst", 32'h100, 32'h1, 1'b1, 32'h102, 1'b0, 1'b0);
        drain();

        rand_ready = 1;
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = 32'h7FFF_FFF0 + $urandom_range(0, 15); b = $urandom_range(0, 31); end
                2: begin a = 32'h8000_0000 + $urandom_range(0, 15); b = 32'hFFFF_FFE0 + $urandom_range(0, 31); end
                default: begin a = $urandom_range(0, 255); b = $urandom_range(0, 255); end
            endcase
            send(a, b, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        rand_ready = 0;
        forced_ready = 1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/add_pipe_stage.md
Name: add_pipe_stage

Overview:
- Two-stage valid/ready pipeline that feeds the team's combinational WIDTH-bit carry-lookahead adder and registers its results.
- Stage 1 captures A, B and Cin from the upstream producer and drives the adder.
- Stage 2 captures Sum, Cout and Overflow for the downstream consumer.
- Also keeps a sticky overflow flag and a wrapping count of delivered results, for datapath monitoring.

Parameters:
WIDTH, 32, operand/sum width; must be a multiple of 4 (instantiated adder is built from 4-bit lookahead groups)
CNT_W, 8, width of the delivered-result counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream operand valid
in_ready  output  1  stage 1 can accept operands
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry in
out_valid  output  1  stage 2 holds a result
out_ready  input  1  downstream accepts result
out_sum  output  WIDTH  registered sum
out_cout  output  1  registered carry out
out_ovf  output  1  registered signed overflow for this result
sticky_ovf  output  1  set by any delivered overflowing result
sticky_clr  input  1  clears sticky_ovf
result_cnt  output  CNT_W  number of results delivered, modulo 2^CNT_W

Behaviour:
- Reset (rst=1 at a rising edge): s1_valid=0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, sticky_ovf=0, result_cnt=0. Operand registers are cleared to 0. Reset mid-operation discards all in-flight data, with no partial delivery.
- Handshake rules:
  - Transfer occurs when valid and ready are both 1 at the rising edge.
  - in_valid and operands must stay stable while in_valid=1 and in_ready=0.
  - out_sum, out_cout and out_ovf stay stable while out_valid=1 and out_ready=0.
- Stage-advance rules:
  - s2_free = !out_valid | out_ready.
  - s1 advances into s2 when s1_valid & s2_free.
  - in_ready = !s1_valid | s2_free, which is combinational from out_ready. No skid buffer.
- Full throughput: 1 result/cycle with out_ready held at 1.
- Latency: operands accepted at edge N appear with out_valid=1 after edge N+1 (2-cycle latency).
- Arithmetic:
  - {cout,sum} = a + b + cin, computed over WIDTH+1 bits.
  - ovf = ~(a[W-1]^b[W-1]) & (a[W-1]^sum[W-1]), evaluated on the raw sum. Cin does not enter the ovf formula.
- Simultaneous events in one cycle:
  - Accept into s1, move s1 to s2 and deliver from s2 may all occur together.
  - Back-pressure (out_ready=0 with out_valid=1) holds both stages.
  - in_ready drops only when s1 is also full.
- result_cnt:
  - Increments on each out_valid & out_ready.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- sticky_ovf:
  - Set on a delivery with out_ovf=1.
  - sticky_clr clears it.
  - If sticky_clr and an overflowing delivery occur in the same cycle, set wins and the flag ends at 1.
- State per stage: EMPTY/FULL (valid bit). Transitions:
  - EMPTY->FULL on load.
  - FULL->EMPTY on drain without reload.
  - FULL->FULL on drain with reload, or on hold.

Optional Feature:
- Macro ADD_PIPE_SAT_EN.
- Defined: when ovf=1, stage 2 loads a saturated result, as below. out_ovf and sticky_ovf still report the overflow.
  - Positive overflow (a[W-1]=0): out_sum = {1'b0,{W-1{1'b1}}}.
  - Negative overflow: out_sum = {1'b1,{W-1{1'b0}}}.
  - out_cout is unchanged from the raw result.
- Undefined: out_sum is the raw wrapped sum. No extra logic.

Test Plan:
- Reset then single transfer: a=0x00000005, b=0x00000003, cin=1 -> 2 cycles later out_valid=1, out_sum=0x00000009, out_cout=0, out_ovf=0, result_cnt=1 after accept.
- Carry out: a=0xFFFFFFFF, b=0x00000001, cin=0 -> out_sum=0x00000000, out_cout=1, out_ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001 -> out_ovf=1 and sticky_ovf=1 after delivery.
  - With ADD_PIPE_SAT_EN: out_sum=0x7FFFFFFF.
  - Without ADD_PIPE_SAT_EN: out_sum=0x80000000.
  - Repeat with a=0x80000000, b=0xFFFFFFFF -> saturated 0x80000000 (or raw 0x7FFFFFFF), out_cout=1.
- Back-pressure: stream 4 operand pairs with out_ready=0 -> in_ready=0 after 2 accepts. Release out_ready -> 4 results in order, no loss or duplication, 1/cycle.
- Counter wrap and sticky priority: CNT_W=2, deliver 5 results -> result_cnt=1. Assert sticky_clr in the same cycle as an overflowing delivery -> sticky_ovf=1. sticky_clr alone -> 0.
- Reset mid-flight: both stages full, assert rst for 1 cycle -> out_valid=0, in_ready=1, result_cnt=0, and no stale result appears afterwards.
